// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM for a multi-cycle RV32I core. Sequences the
//            shared ALU, register file, PC and unified memory over several
//            cycles per instruction and drives ALUOp into the ALU decoder
//            (000 add, 001 sub, 010 funct-decoded, 011 load/store, 100 lui).
//            Stalls on the memory ready handshake and flags unsupported
//            opcodes with a one-cycle pulse.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            op, funct3, zero   - IR opcode/funct3 and ALU zero flag
//            mem_ready          - memory access completes this cycle
//            PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//            ALUSrcB, ALUOp, RegWrite - datapath controls
//            illegal            - unsupported opcode seen in DECODE
//            state_dbg          - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } state_t;

  state_t state;
  state_t next_state;

  // Only funct3[0] distinguishes beq/bne; the upper bits are don't-care.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  assign state_dbg = state;

  always_comb begin
    next_state = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    RegWrite   = 1'b0;
    illegal    = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 computed and written back in the same cycle the IR loads.
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // OldPC + imm precomputes the branch target into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_LUI:            next_state = LUI;
          default: begin
            // Treated as a NOP: PC was already advanced in FETCH.
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 3'b011;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        // Strobe held through the wait, including the completing cycle.
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 3'b010;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 3'b010;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        // Compare by subtraction; ALUOut already holds the target.
        ALUSrcA    = 2'b10;
        ALUOp      = 3'b001;
        PCWrite    = zero ^ funct3[0];
        next_state = FETCH;
      end
      JAL: begin
        // OldPC+4 goes to rd via ALUWB while PC takes the target in ALUOut.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = ALUWB;
      end
      LUI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 3'b100;
        next_state = ALUWB;
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    // While reset is held, no architectural state may change.
    if (rst) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl. Each cycle the
//            full output word is compared against a hand-built expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct3    (funct3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  // Observed word: state,PCW,Adr,MemW,IRW,Res,A,B,ALUOp,RegW,illegal
  logic [18:0] obs;
  assign obs = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal};

  function automatic logic [18:0] ev(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] a, input logic [1:0] b, input logic [2:0] aop,
      input logic rw, input logic ill);
    return {st, pcw, adr, mw, irw, rs, a, b, aop, rw, ill};
  endfunction

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] rst_vec;
    logic [18:0] exp;
    rst_vec = ev(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    rst = 1'b1; mem_ready = 1'b1; op = OPC_SW; funct3 = 3'b000; zero = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== rst_vec) begin
      n_bad++;
      $display("FAIL reset_hold: got %h expected %h", obs, rst_vec);
    end
    tick();
    rst = 1'b0;
    // Walk a store up to MEMWRITE, stalled on mem_ready.
    tick();                       // FETCH -> DECODE
    tick();                       // DECODE -> MEMADR
    mem_ready = 1'b0;
    tick();                       // MEMADR -> MEMWRITE
    @(negedge clk);
    exp = ev(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_pre_memwrite: got %h expected %h", obs, exp);
    end
    #2;
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== rst_vec) begin
      n_bad++;
      $display("FAIL reset_mid_memwrite: got %h expected %h", obs, rst_vec);
    end
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    exp = ev(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_release_wait: got %h expected %h", obs, exp);
    end
    mem_ready = 1'b1;
    #1;
    exp = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_first_irwrite: got %h expected %h", obs, exp);
    end
    mem_ready = 1'b0;             // hold in FETCH for the next test
    tick();
  endtask

  task automatic test_add();
    logic [18:0] exp [4];
    exp[0] = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[1] = ev(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    exp[2] = ev(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0, 0);
    exp[3] = ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    op = OPC_R; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL add cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_addi();
    logic [18:0] exp [4];
    exp[0] = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[1] = ev(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    exp[2] = ev(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 0, 0);
    exp[3] = ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    op = OPC_I; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL addi cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_lw_stall();
    logic [18:0] exp [9];
    logic [8:0]  mr;
    mr = 9'b0_1000_0100;          // bit i = mem_ready in cycle i
    exp[0] = ev(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[1] = exp[0];
    exp[2] = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[3] = ev(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    exp[4] = ev(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 0, 0);
    exp[5] = ev(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    exp[6] = exp[5];
    exp[7] = exp[5];
    exp[8] = ev(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0);
    op = OPC_LW;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL lw cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw_stall();
    logic [18:0] exp [5];
    logic [4:0]  mr;
    mr = 5'b10111;
    exp[0] = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[1] = ev(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    exp[2] = ev(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 0, 0);
    exp[3] = ev(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    exp[4] = exp[3];
    op = OPC_SW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL sw cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    // Cases: beq z=1 (taken), bne z=1, beq z=0, bne z=0 (taken)
    logic [3:0] zs, f0s, taken;
    logic [18:0] exp;
    zs = 4'b0011; f0s = 4'b1010; taken = 4'b1001;
    op = OPC_B; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      zero = zs[c];
      funct3 = {2'b00, f0s[c]};
      tick();                     // FETCH -> DECODE
      tick();                     // DECODE -> BRANCH
      @(negedge clk);
      exp = ev(4'd9, taken[c], 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL branch case%0d: got %h expected %h", c, obs, exp);
      end
      tick();                     // BRANCH -> FETCH
    end
    zero = 1'b0; funct3 = 3'b000;
  endtask

  task automatic test_illegal();
    logic [18:0] exp [3];
    logic [2:0]  mr;
    mr = 3'b011;
    exp[0] = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[1] = ev(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 1);
    exp[2] = ev(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    op = OPC_SYS;
    for (int i = 0; i < 3; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // jal immediately followed by lui
    logic [18:0] exp [8];
    logic [6:0]  ops [8];
    exp[0] = ev(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    exp[1] = ev(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    exp[2] = ev(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0);
    exp[3] = ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    exp[4] = exp[0];
    exp[5] = exp[1];
    exp[6] = ev(4'd11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 0, 0);
    exp[7] = exp[3];
    for (int i = 0; i < 8; i++) ops[i] = (i < 4) ? OPC_JAL : OPC_LUI;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = ops[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL jal_lui cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_lw_stall();
    test_sw_stall();
    test_branch();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
